// File: rtl/mfcc_pkg.sv
// Shared MFCC front-end definitions: FFT framing constants, feeder FSM states
// and a saturation helper used by the power path.
package mfcc_pkg;

  localparam int NFFT       = 512;
  localparam int NRFFT      = NFFT / 2 + 1;
  localparam int NRFFT_LOG2 = $clog2(NRFFT);

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DRAIN    = 2'd1,
    START    = 2'd2,
    WAIT_MEL = 2'd3
  } feeder_state_e;

  // Clamp v to the largest unsigned value representable in w bits (w < 64).
  function automatic logic [63:0] sat_to_width(input logic [63:0] v, input int w);
    logic [63:0] lim;
    lim = (64'd1 << w) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/power_spectrum_feeder_power_sq.sv
// Two-stage |X|^2 pipeline: squares in S1, sum/shift/saturate into the
// registered spectrum write in S2. Valid/pointer ride alongside; no stall.
module power_sq #(
  parameter int FFT_WIDTH    = 16,
  parameter int OUTPUT_WIDTH = 32,
  parameter int PS_SHIFT     = 0,
  parameter int PTR_W        = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        vld_i,
  input  logic [PTR_W-1:0]            ptr_i,
  input  logic signed [FFT_WIDTH-1:0] re_i,
  input  logic signed [FFT_WIDTH-1:0] im_i,
  output logic                        pend_o,
  output logic                        vld_o,
  output logic [PTR_W-1:0]            ptr_o,
  output logic [OUTPUT_WIDTH-1:0]     data_o
);
  import mfcc_pkg::*;

  localparam int STAGES = 2;
  localparam int PW     = 2 * FFT_WIDTH;
  localparam int SW     = PW + 1;

  logic [STAGES:1]         vld_pipe_q;
  logic [PTR_W-1:0]        ptr1_q, ptr2_q;
  logic [PW-1:0]           re_sq_q, im_sq_q;
  logic [OUTPUT_WIDTH-1:0] data_q, data_d;

  logic signed [PW-1:0] re_sq, im_sq;
  logic [SW-1:0]        sum, shifted;
  logic [63:0]          sat64;

  assign re_sq = re_i * re_i;
  assign im_sq = im_i * im_i;

  // Squares are never negative, so the sum fits one extra bit unsigned.
  assign sum     = {1'b0, re_sq_q} + {1'b0, im_sq_q};
  assign shifted = sum >> PS_SHIFT;
  assign sat64   = sat_to_width(64'(shifted), OUTPUT_WIDTH);
  assign data_d  = sat64[OUTPUT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      ptr1_q     <= '0;
      ptr2_q     <= '0;
      re_sq_q    <= '0;
      im_sq_q    <= '0;
      data_q     <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], vld_i};
      ptr1_q     <= ptr_i;
      re_sq_q    <= re_sq;
      im_sq_q    <= im_sq;
      ptr2_q     <= ptr1_q;
      data_q     <= data_d;
    end
  end

  assign pend_o = vld_pipe_q[1];
  assign vld_o  = vld_pipe_q[STAGES];
  assign ptr_o  = ptr2_q;
  assign data_o = data_q;

endmodule

// File: rtl/power_spectrum_feeder.sv
// Producer for the Mel filterbank spectrum load: streams FFT bins through the
// power pipeline into spectrum memory, kicks the filterbank, waits for done.
module power_spectrum_feeder #(
  parameter int NFFT         = 512,
  parameter int NRFFT        = NFFT / 2 + 1,
  parameter int NRFFT_LOG2   = $clog2(NRFFT),
  parameter int FFT_WIDTH    = 16,
  parameter int OUTPUT_WIDTH = 32,
  parameter int PS_SHIFT     = 0,
  parameter int MEL_TIMEOUT  = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fft_valid_i,
  output logic                        fft_ready_o,
  input  logic signed [FFT_WIDTH-1:0] fft_real_i,
  input  logic signed [FFT_WIDTH-1:0] fft_imag_i,
  input  logic                        fft_last_i,
  output logic                        ps_valid_o,
  output logic [NRFFT_LOG2-1:0]       ps_ptr_o,
  output logic [OUTPUT_WIDTH-1:0]     ps_data_o,
  output logic                        mel_start_o,
  input  logic                        mel_done_i,
  output logic                        busy_o,
  output logic                        frame_err_o,
  output logic                        timeout_o
);
  import mfcc_pkg::*;

  localparam int TMO_W = $clog2(MEL_TIMEOUT + 1);

  feeder_state_e state_q, state_d;
  logic [NRFFT_LOG2-1:0]       k_q, k_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic                        err_q, err_d;
  logic                        tflag_q, tflag_d;
  logic                        done_q;

  logic                        in_vld_q;
  logic [NRFFT_LOG2-1:0]       in_ptr_q;
  logic signed [FFT_WIDTH-1:0] in_re_q, in_im_q;

  logic accept, last_bin, done_rise, pend;

  assign accept    = fft_valid_i && (state_q == COLLECT);
  assign last_bin  = (k_q == NRFFT_LOG2'(NRFFT - 1));
  assign done_rise = mel_done_i && !done_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    tflag_d = tflag_q;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          // The bin counter owns framing; fft_last_i is only cross-checked.
          if (fft_last_i != last_bin) err_d = 1'b1;
          if (last_bin) begin
            k_d     = '0;
            state_d = DRAIN;
          end else begin
            k_d = k_q + NRFFT_LOG2'(1);
          end
        end
      end
      DRAIN: begin
        // Last write is on the output this cycle or already gone.
        if (!in_vld_q && !pend) state_d = START;
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT_MEL;
      end
      WAIT_MEL: begin
        if (done_rise) begin
          state_d = COLLECT;
        end else if (tmo_q == TMO_W'(MEL_TIMEOUT - 1)) begin
          tflag_d = 1'b1;
          state_d = COLLECT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      k_q      <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      tflag_q  <= 1'b0;
      done_q   <= 1'b0;
      in_vld_q <= 1'b0;
      in_ptr_q <= '0;
      in_re_q  <= '0;
      in_im_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      tflag_q  <= tflag_d;
      done_q   <= mel_done_i;
      in_vld_q <= accept;
      if (accept) begin
        in_ptr_q <= k_q;
        in_re_q  <= fft_real_i;
        in_im_q  <= fft_imag_i;
      end
    end
  end

  power_sq #(
    .FFT_WIDTH    (FFT_WIDTH),
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .PS_SHIFT     (PS_SHIFT),
    .PTR_W        (NRFFT_LOG2)
  ) u_power_sq (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (in_vld_q),
    .ptr_i  (in_ptr_q),
    .re_i   (in_re_q),
    .im_i   (in_im_q),
    .pend_o (pend),
    .vld_o  (ps_valid_o),
    .ptr_o  (ps_ptr_o),
    .data_o (ps_data_o)
  );

  assign fft_ready_o = (state_q == COLLECT);
  assign mel_start_o = (state_q == START);
  assign busy_o      = !((state_q == COLLECT) && (k_q == '0));
  assign frame_err_o = err_q;
  assign timeout_o   = tflag_q;

endmodule

// File: tb/tb_power_spectrum_feeder.sv
// Scoreboard bench: three feeders in lockstep (32-bit, 24-bit, 24-bit >>8)
// share one bin stream; expected writes are queued on acceptance.
module tb_power_spectrum_feeder;
  localparam int NR = 257;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               fft_valid = 1'b0, fft_last = 1'b0, mel_done = 1'b0;
  logic signed [15:0] re = '0, im = '0;

  logic        rdy, psv, start, busy, ferr, tmo;
  logic [8:0]  ptr;
  logic [31:0] d32;
  logic        rdy_a, psv_a, start_a, busy_a, ferr_a, tmo_a;
  logic [8:0]  ptr_a;
  logic [23:0] d24;
  logic        rdy_b, psv_b, start_b, busy_b, ferr_b, tmo_b;
  logic [8:0]  ptr_b;
  logic [23:0] d24s;

  power_spectrum_feeder #(.OUTPUT_WIDTH(32), .PS_SHIFT(0), .MEL_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .fft_valid_i(fft_valid), .fft_ready_o(rdy),
    .fft_real_i(re), .fft_imag_i(im), .fft_last_i(fft_last),
    .ps_valid_o(psv), .ps_ptr_o(ptr), .ps_data_o(d32), .mel_start_o(start),
    .mel_done_i(mel_done), .busy_o(busy), .frame_err_o(ferr), .timeout_o(tmo));

  power_spectrum_feeder #(.OUTPUT_WIDTH(24), .PS_SHIFT(0), .MEL_TIMEOUT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .fft_valid_i(fft_valid), .fft_ready_o(rdy_a),
    .fft_real_i(re), .fft_imag_i(im), .fft_last_i(fft_last),
    .ps_valid_o(psv_a), .ps_ptr_o(ptr_a), .ps_data_o(d24), .mel_start_o(start_a),
    .mel_done_i(mel_done), .busy_o(busy_a), .frame_err_o(ferr_a), .timeout_o(tmo_a));

  power_spectrum_feeder #(.OUTPUT_WIDTH(24), .PS_SHIFT(8), .MEL_TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .fft_valid_i(fft_valid), .fft_ready_o(rdy_b),
    .fft_real_i(re), .fft_imag_i(im), .fft_last_i(fft_last),
    .ps_valid_o(psv_b), .ps_ptr_o(ptr_b), .ps_data_o(d24s), .mel_start_o(start_b),
    .mel_done_i(mel_done), .busy_o(busy_b), .frame_err_o(ferr_b), .timeout_o(tmo_b));

  typedef struct {
    int     ptr;
    longint d32;
    longint d24;
    longint d24s;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   starts = 0;
  int   last_wr = -1;
  int   kk = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int p, input logic signed [15:0] r, input logic signed [15:0] i);
    exp_t   e;
    longint s;
    s      = longint'(r) * longint'(r) + longint'(i) * longint'(i);
    e.ptr  = p;
    e.d32  = s;
    e.d24  = (s > 64'hFFFFFF) ? 64'hFFFFFF : s;
    e.d24s = ((s >> 8) > 64'hFFFFFF) ? 64'hFFFFFF : (s >> 8);
    return e;
  endfunction

  // Pop the write on the bus, then queue whatever is accepted at the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (psv) begin
      if (q.size() == 0) chk("unexpected_wr", psv, 0);
      else begin
        e = q.pop_front();
        chk("ptr", ptr, e.ptr);
        chk("d32", d32, e.d32);
        chk("d24_sat", d24, e.d24);
        chk("d24_shift8", d24s, e.d24s);
        chk("lockstep", {psv_a, psv_b}, 2'b11);
      end
      last_wr = int'(ptr);
    end
    if (start) begin
      starts++;
      chk("start_with_ps", psv, 0);
      chk("start_after_last", last_wr, NR - 1);
    end
    if (!rst_n) begin
      q.delete();
      kk = 0;
    end else if (fft_valid && rdy) begin
      q.push_back(model(kk, re, im));
      kk = (kk == NR - 1) ? 0 : kk + 1;
    end
  end

  task automatic send(input logic signed [15:0] r, input logic signed [15:0] i, input logic l);
    int n;
    @(posedge clk); #1;
    re = r; im = i; fft_last = l; fft_valid = 1'b1;
    n = 0;
    while (!rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("accept_timeout", n, 0);
  endtask

  task automatic wait_start(input int s0);
    int n;
    n = 0;
    while (starts == s0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("start_pulses", starts, s0 + 1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_return", rdy, 1);
  endtask

  initial begin
    int s0, n;
    logic [31:0] rnd;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rdy, 1);
    chk("rst_psv", psv, 0);
    chk("rst_data", d32, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_tmo", tmo, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Frame A: re=k, im=0
    s0 = starts;
    for (int k = 0; k < NR; k++) send(16'(k), 16'sd0, k == NR - 1);
    @(posedge clk); #1;
    chk("ready_low_after_last", rdy, 0);
    chk("busy_after_last", busy, 1);
    // Backpressure: valid stays high holding frame B bin 0
    re = -16'sd32768; im = -16'sd32768; fft_last = 1'b0;
    wait_start(s0);
    repeat (8) begin
      @(posedge clk); #1;
      chk("bp_ready", rdy, 0);
    end
    mel_done = 1'b1;
    chk("ready_before_edge", rdy, 0);
    @(posedge clk); #1;
    chk("ready_after_done", rdy, 1);
    chk("tmo_after_done", tmo, 0);

    // Frame B: extremes, then random; done held high so WAIT_MEL times out
    s0 = starts;
    send(16'sd32767, 16'sd0, 1'b0);
    send(16'sd0, 16'sd0, 1'b0);
    for (int k = 3; k < NR; k++) begin
      rnd = $urandom();
      send(rnd[15:0], rnd[31:16], k == NR - 1);
    end
    @(posedge clk); #1;
    fft_valid = 1'b0;
    wait_start(s0);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (rdy) break;
    end
    chk("wait_mel_cycles", n, 17);
    chk("timeout_flag", tmo, 1);
    chk("ferr_clean", ferr, 0);

    // Frame C: spurious last on bin 100, none on bin 256
    mel_done = 1'b0;
    s0 = starts;
    for (int k = 0; k < NR; k++) begin
      rnd = $urandom();
      send(rnd[15:0], rnd[31:16], k == 100);
      if (k == 100) chk("ferr_before", ferr, 0);
    end
    @(posedge clk); #1;
    fft_valid = 1'b0;
    fft_last = 1'b0;
    chk("ferr_set", ferr, 1);
    wait_start(s0);
    wait_ready();

    // Frame D: reset mid-frame
    for (int k = 0; k < 5; k++) send(16'(k + 1), 16'sd2, 1'b0);
    @(posedge clk); #1;
    fft_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_psv", psv, 0);
    chk("mid_rst_ptr", ptr, 0);
    chk("mid_rst_data", d32, 0);
    chk("mid_rst_start", start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ferr", ferr, 0);
    chk("mid_rst_tmo", tmo, 0);
    chk("mid_rst_ready", rdy, 1);
    repeat (4) @(posedge clk);
    send(16'sd7, 16'sd3, 1'b0);
    @(posedge clk); #1;
    fft_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    chk("last_ptr_after_rst", last_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 1 exp 0");
    $fatal(1);
  end

endmodule

// File: doc/power_spectrum_feeder.md
Name: power_spectrum_feeder

Overview:
- Producer side of the Mel filterbank's spectrum-load interface.
- Accepts streamed one-sided FFT bins (signed real/imag) with valid/ready, computes |X[k]|^2, and scales/saturates it.
- Writes each value with a bin pointer and write strobe into the filterbank's spectrum memory.
- After the last bin it pulses the filterbank start, then holds off the next frame until the filterbank reports done.

Parameters:
- NFFT, 512, FFT length.
- NRFFT, NFFT/2+1, bins per frame (257).
- NRFFT_LOG2, $clog2(NRFFT), bin pointer width (9).
- FFT_WIDTH, 16, signed width of fft_real_i / fft_imag_i.
- OUTPUT_WIDTH, 32, width of ps_data_o; must equal the filterbank INPUT_WIDTH.
- PS_SHIFT, 0, right shift applied to |X|^2 before saturation.
- MEL_TIMEOUT, 4096, maximum cycles spent in WAIT_MEL.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- fft_valid_i  in  1  bin beat valid.
- fft_ready_o  out  1  bin beat accepted when valid&&ready.
- fft_real_i  in  FFT_WIDTH  signed real part.
- fft_imag_i  in  FFT_WIDTH  signed imag part.
- fft_last_i  in  1  source marks final bin of frame.
- ps_valid_o  out  1  spectrum write strobe.
- ps_ptr_o  out  NRFFT_LOG2  bin index of the write.
- ps_data_o  out  OUTPUT_WIDTH  power value of the write.
- mel_start_o  out  1  one-cycle start pulse to the filterbank.
- mel_done_i  in  1  filterbank done (level).
- busy_o  out  1  high in any state except COLLECT with bin count 0.
- frame_err_o  out  1  sticky: fft_last_i disagreed with bin count.
- timeout_o  out  1  sticky: WAIT_MEL exited by timeout.

Behaviour:
- Reset (rst_n low at clk edge) clears state to COLLECT and bin count to 0. All outputs are 0 except fft_ready_o=1. Pipeline valids, frame_err_o and timeout_o are also cleared.
- Reset mid-frame discards in-flight beats; no ps_valid_o is issued after reset.
- FSM states: COLLECT, DRAIN, START, WAIT_MEL.
- COLLECT: fft_ready_o=1.
  - Each accepted beat enters the pipeline tagged with bin count k, then k increments.
  - The beat accepted with k==NRFFT-1 moves the FSM to DRAIN and resets k to 0.
- Counter is authoritative: if fft_last_i=1 with k!=NRFFT-1, or fft_last_i=0 with k==NRFFT-1, set frame_err_o. Framing is unchanged by the mismatch.
- Pipeline, 2 stages, no stall (writes cannot be back-pressured):
  - S1 registers re*re and im*im, each 2*FFT_WIDTH bits unsigned.
  - S2 forms sum = re^2+im^2 (2*FFT_WIDTH+1 bits), then shifted = sum>>PS_SHIFT.
  - ps_data_o = shifted if shifted < 2^OUTPUT_WIDTH, else all ones.
  - ps_valid_o/ps_ptr_o/ps_data_o are registered.
  - Latency: a beat accepted at edge n gives ps_valid_o=1 in the cycle after edge n+2.
- DRAIN: fft_ready_o=0. Exits to START when the pipeline is empty, i.e. the ps write of bin NRFFT-1 has been issued.
- START: mel_start_o=1 for exactly one cycle, then WAIT_MEL. mel_start_o is never asserted in the same cycle as ps_valid_o.
- WAIT_MEL: fft_ready_o=0.
  - Rising edge of mel_done_i (sampled low on the previous cycle, high now) returns the FSM to COLLECT.
  - A done level already high on entry does not count as an edge.
  - After MEL_TIMEOUT cycles without an edge, set timeout_o and return to COLLECT.
- fft_ready_o depends only on state (registered), not on fft_valid_i.

Decomposition:
- Shared package mfcc_pkg holds:
  - NFFT / NRFFT / NRFFT_LOG2 constants, shared with the filterbank.
  - The feeder FSM state enum.
  - A saturate-to-width function.
- One sub-module, power_sq, for the 2-stage squaring/saturation pipeline. It has valid and pointer sideband and no handshake.

Test Plan:
- Frame with re=k, im=0 for k=0..256, valid every cycle:
  - ps writes ptr=k, data=k*k, each 2 cycles after acceptance.
  - One mel_start_o pulse after ptr=256 is written.
  - fft_ready_o low from the cycle after bin 256 is accepted.
- Extremes:
  - re=im=-32768 → data=0x80000000.
  - re=32767, im=0 → 0x3FFF0001.
  - re=im=0 → 0.
- OUTPUT_WIDTH=24, PS_SHIFT=0, re=im=-32768 → data=0xFFFFFF (saturated). With PS_SHIFT=8 → 0x800000.
- Backpressure: keep fft_valid_i high through WAIT_MEL with mel_done_i low.
  - No beats accepted and no ps writes.
  - Raise mel_done_i → ready returns 1 next cycle and the next frame starts at ptr=0.
- Hold mel_done_i high continuously with MEL_TIMEOUT=16:
  - Second frame's WAIT_MEL lasts 16 cycles.
  - Then timeout_o=1 and COLLECT resumes.
- fft_last_i asserted on bin 100 → frame_err_o=1, and the frame still completes at bin 256. Then pulse rst_n low mid-frame → all outputs and sticky flags are 0, and the next beat is written to ptr=0.
